// File: rtl/lathe_panel_conditioner.sv
// Operator-panel front end for the lathe spindle controller.
// Synchronises and debounces the panel inputs, decodes the AUTO/MAN selector,
// seals in RUN from momentary START/STOP and latches e-stop in FAULT.
// Optional jog support is built when LATHE_PANEL_JOG_EN is defined.
module lathe_panel_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic auto_sel,
  input  logic man_sel,
  input  logic estop_n,
  input  logic jog_btn,
  output logic start_o,
  output logic auto_o,
  output logic man_o,
  output logic mode_fault,
  output logic estop_active,
  output logic jog_active
);

  // Channel map: 0 start, 1 stop, 2 auto, 3 man, 4 estop_n, 5 jog (optional)
`ifdef LATHE_PANEL_JOG_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 5;
`endif
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_FAULT = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [NCH-1:0] raw;
`ifdef LATHE_PANEL_JOG_EN
  assign raw = {jog_btn, estop_n, man_sel, auto_sel, stop_btn, start_btn};
`else
  logic unused_jog;
  assign unused_jog = jog_btn;
  assign raw = {estop_n, man_sel, auto_sel, stop_btn, start_btn};
`endif

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]                  sync;
  logic [NCH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NCH-1:0]                  db_q, db_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; keeps running regardless of ena
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Debounce: count cycles of disagreement, adopt the new level at the limit
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (ena) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (sync[ch] == db_q[ch]) begin
          cnt_d[ch] = '0;
        end else if (cnt_q[ch] == CNT_MAX) begin
          db_d[ch]  = sync[ch];
          cnt_d[ch] = '0;
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  // Debounce state registers; estop_n resets to 0 so the block starts in FAULT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  logic db_start, db_stop, db_auto, db_man, db_estop, db_jog, mode_valid;
  assign db_start   = db_q[0];
  assign db_stop    = db_q[1];
  assign db_auto    = db_q[2];
  assign db_man     = db_q[3];
  assign db_estop   = db_q[4];
`ifdef LATHE_PANEL_JOG_EN
  assign db_jog     = db_q[5];
`else
  assign db_jog     = 1'b0;
`endif
  assign mode_valid = db_auto ^ db_man;

  logic [1:0] state_q, state_d;
  logic       lat_auto_q, lat_auto_d;
  logic       prev_start_q, prev_start_d;
  logic       start_q, start_d, jog_q, jog_d;
  logic       auto_q, auto_d, man_q, man_d, mf_q, mf_d, estop_q, estop_d;

  // Mode decode and FAULT/IDLE/RUN sequencing; raw-synchronised e-stop wins over all
  always_comb begin
    state_d      = state_q;
    lat_auto_d   = lat_auto_q;
    prev_start_d = prev_start_q;
    start_d      = start_q;
    jog_d        = jog_q;
    auto_d       = auto_q;
    man_d        = man_q;
    mf_d         = mf_q;
    if (ena) begin
      prev_start_d = db_start;
      auto_d       = db_auto & ~db_man;
      man_d        = db_man & ~db_auto;
      mf_d         = db_auto & db_man;
      case (state_q)
        ST_FAULT: if (db_estop && !db_start) state_d = ST_IDLE;
        ST_IDLE: begin
          // start edge failing any condition is dropped, never queued
          if (db_start && !prev_start_q && mode_valid && !db_stop && db_estop) begin
            state_d    = ST_RUN;
            lat_auto_d = db_auto;
          end
        end
        ST_RUN: if (db_stop || !mode_valid || (db_auto != lat_auto_q)) state_d = ST_IDLE;
        default: state_d = ST_FAULT;
      endcase
      jog_d   = (state_q == ST_IDLE) && (state_d == ST_IDLE) && db_man && !db_auto &&
                db_jog && db_estop && !db_stop;
      start_d = (state_d == ST_RUN) || jog_d;
    end
    if (!sync[4]) begin
      state_d = ST_FAULT;
      start_d = 1'b0;
      jog_d   = 1'b0;
    end
    estop_d = (state_d == ST_FAULT);
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FAULT;
      lat_auto_q   <= 1'b0;
      prev_start_q <= 1'b0;
      start_q      <= 1'b0;
      jog_q        <= 1'b0;
      auto_q       <= 1'b0;
      man_q        <= 1'b0;
      mf_q         <= 1'b0;
      estop_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      lat_auto_q   <= lat_auto_d;
      prev_start_q <= prev_start_d;
      start_q      <= start_d;
      jog_q        <= jog_d;
      auto_q       <= auto_d;
      man_q        <= man_d;
      mf_q         <= mf_d;
      estop_q      <= estop_d;
    end
  end

  assign start_o      = start_q;
  assign auto_o       = auto_q;
  assign man_o        = man_q;
  assign mode_fault   = mf_q;
  assign estop_active = estop_q;
  assign jog_active   = jog_q;

endmodule

// File: tb/tb_lathe_panel_conditioner.sv
// Bench for lathe_panel_conditioner: directed panel scenarios then random panel
// activity, all compared against a window-based reference model.
module tb_lathe_panel_conditioner;
  localparam int D = 4;
  localparam int S = 2;
`ifdef LATHE_PANEL_JOG_EN
  localparam bit JOG_ON = 1'b1;
`else
  localparam bit JOG_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic start_btn = 0, stop_btn = 0, auto_sel = 0, man_sel = 0, estop_n = 1, jog_btn = 0;
  logic start_o, auto_o, man_o, mode_fault, estop_active, jog_active;

  lathe_panel_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start_btn(start_btn), .stop_btn(stop_btn),
    .auto_sel(auto_sel), .man_sel(man_sel), .estop_n(estop_n), .jog_btn(jog_btn),
    .start_o(start_o), .auto_o(auto_o), .man_o(man_o), .mode_fault(mode_fault),
    .estop_active(estop_active), .jog_active(jog_active));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: input history, samples seen at enabled edges, debounced levels
  typedef enum int {M_FAULT, M_IDLE, M_RUN} mst_t;
  logic [5:0] raw_h[$];
  logic [5:0] en_h[$];
  logic [5:0] m_db;
  logic m_prev, m_lat;
  mst_t m_st;
  logic e_start, e_auto, e_man, e_mf, e_estop, e_jog;

  task automatic model_reset();
    raw_h.delete(); en_h.delete();
    m_db = '0; m_prev = 0; m_lat = 0; m_st = M_FAULT;
    e_start = 0; e_auto = 0; e_man = 0; e_mf = 0; e_estop = 1; e_jog = 0;
  endtask

  task automatic model_edge();
    logic [5:0] in, sy, od, nd;
    logic st, sp, a, m, es, jg, valid, rise;
    mst_t ns;
    in = {jog_btn, estop_n, man_sel, auto_sel, stop_btn, start_btn};
    raw_h.push_back(in);
    // synchronised value presented at this edge is the input from S edges earlier
    sy = (raw_h.size() > S) ? raw_h[raw_h.size()-1-S] : 6'd0;
    if (raw_h.size() > S + 1) void'(raw_h.pop_front());
    od = m_db;
    st = od[0]; sp = od[1]; a = od[2]; m = od[3]; es = od[4]; jg = od[5] & JOG_ON;
    if (ena) begin
      valid = (a != m);
      rise  = st && !m_prev;
      ns = m_st;
      case (m_st)
        M_FAULT: if (es && !st) ns = M_IDLE;
        M_IDLE:  if (rise && valid && !sp && es) begin ns = M_RUN; m_lat = a; end
        M_RUN:   if (sp || !valid || (a != m_lat)) ns = M_IDLE;
        default: ns = M_FAULT;
      endcase
      e_jog   = JOG_ON && (m_st == M_IDLE) && (ns == M_IDLE) && m && !a && jg && es && !sp;
      m_st    = ns;
      e_start = (ns == M_RUN) || e_jog;
      e_auto  = a && !m;
      e_man   = m && !a;
      e_mf    = a && m;
      m_prev  = st;
      // a level is adopted once the last D enabled samples all disagree with it
      en_h.push_back(sy);
      if (en_h.size() > D) void'(en_h.pop_front());
      nd = od;
      if (en_h.size() == D) begin
        for (int ch = 0; ch < 6; ch++) begin
          bit flip = 1'b1;
          for (int k = 0; k < D; k++) if (en_h[k][ch] == od[ch]) flip = 1'b0;
          if (flip) nd[ch] = ~od[ch];
        end
      end
      m_db = nd;
    end
    if (!sy[4]) begin
      m_st = M_FAULT; e_start = 0; e_jog = 0;
    end
    e_estop = (m_st == M_FAULT);
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("start_o", start_o, e_start);
    chk("auto_o", auto_o, e_auto);
    chk("man_o", man_o, e_man);
    chk("mode_fault", mode_fault, e_mf);
    chk("estop_active", estop_active, e_estop);
    chk("jog_active", jog_active, e_jog);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic press_start();
    start_btn = 1; tick(8);
    start_btn = 0; tick(8);
  endtask

  initial begin
    model_reset();
    // reset values while held in reset
    repeat (2) @(negedge clk);
    chk("rst_start", start_o, 1'b0);
    chk("rst_estop", estop_active, 1'b1);
    chk("rst_auto", auto_o, 1'b0);
    chk("rst_man", man_o, 1'b0);
    chk("rst_mf", mode_fault, 1'b0);
    chk("rst_jog", jog_active, 1'b0);

    // 1: leave reset into FAULT, reach IDLE on cycle 7
    @(negedge clk); rst_n = 1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk("t1_fault", estop_active, 1'b1);
      chk("t1_start", start_o, 1'b0);
    end
    tick(1);
    chk("t1_idle", estop_active, 1'b0);

    // 2: AUTO start seals in, stop drops it
    auto_sel = 1; tick(8);
    chk("t2_auto", auto_o, 1'b1);
    start_btn = 1; tick(6);
    chk("t2_pre", start_o, 1'b0);
    tick(1);
    chk("t2_run", start_o, 1'b1);
    tick(3); start_btn = 0; tick(10);
    chk("t2_held", start_o, 1'b1);
    stop_btn = 1; tick(8);
    chk("t2_stop", start_o, 1'b0);
    stop_btn = 0; tick(8);

    // 3: chattering start never debounces
    for (int i = 0; i < 10; i++) begin
      start_btn = ~start_btn; tick(2);
      chk("t3_bounce", start_o, 1'b0);
    end
    start_btn = 0; tick(8);

    // 4: e-stop fast path, no auto-restart after release
    press_start();
    chk("t4_run", start_o, 1'b1);
    estop_n = 0; tick(3);
    chk("t4_drop", start_o, 1'b0);
    chk("t4_fault", estop_active, 1'b1);
    tick(8);
    start_btn = 1; tick(4); estop_n = 1; tick(10);
    chk("t4_hold_fault", estop_active, 1'b1);
    start_btn = 0; tick(8);
    chk("t4_idle", estop_active, 1'b0);
    chk("t4_norestart", start_o, 1'b0);

    // 5: both contacts closed, then selector change while running
    man_sel = 1; tick(8);
    chk("t5_mf", mode_fault, 1'b1);
    chk("t5_auto0", auto_o, 1'b0);
    chk("t5_man0", man_o, 1'b0);
    press_start();
    chk("t5_nostart", start_o, 1'b0);
    man_sel = 0; tick(8);
    press_start();
    chk("t5_run", start_o, 1'b1);
    auto_sel = 0; man_sel = 1; tick(8);
    chk("t5_modechg", start_o, 1'b0);
    chk("t5_man1", man_o, 1'b1);

    // 6: jog in MAN works, in AUTO ignored (absent in default build)
    jog_btn = 1; tick(7);
    chk("t6_jog_start", start_o, JOG_ON);
    chk("t6_jog_act", jog_active, JOG_ON);
    tick(5); jog_btn = 0; tick(8);
    chk("t6_jog_off", start_o, 1'b0);
    man_sel = 0; auto_sel = 1; tick(8);
    jog_btn = 1; tick(12);
    chk("t6_jog_auto", start_o, 1'b0);
    jog_btn = 0; tick(8);

    // ena=0 freezes the FSM, but e-stop still bites
    press_start();
    ena = 0; stop_btn = 1; tick(10);
    chk("ena_hold", start_o, 1'b1);
    estop_n = 0; tick(3);
    chk("ena_estop", start_o, 1'b0);
    ena = 1; stop_btn = 0; tick(8); estop_n = 1; tick(12);

    // asynchronous reset mid-run
    press_start();
    #2 rst_n = 0; #1;
    chk("arst_start", start_o, 1'b0);
    chk("arst_estop", estop_active, 1'b1);
    model_reset();
    @(negedge clk); rst_n = 1;
    tick(10);

    // random panel activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) start_btn = ~start_btn;
      if ($urandom_range(19) == 0) stop_btn = ~stop_btn;
      if ($urandom_range(29) == 0) auto_sel = ~auto_sel;
      if ($urandom_range(29) == 0) man_sel = ~man_sel;
      if ($urandom_range(79) == 0) estop_n = ~estop_n;
      if ($urandom_range(14) == 0) jog_btn = ~jog_btn;
      ena = ($urandom_range(9) != 0);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
